// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Instruction fetch stage in front of the instruction register.
//               It drives the instruction memory read address, hides the
//               memory's one-cycle read latency, and buffers each returned
//               word with its PC in a DEPTH-entry FIFO. The FIFO hands words
//               to the consumer through a valid/ready handshake. A redirect
//               flushes the queue and restarts fetch at a new PC.
// Ports       : clk          - clock, rising-edge active
//               rst_n        - asynchronous active-low reset
//               fetch_en     - allows new fetch requests to issue
//               imem_raddr   - memory read address (low 32 bits of fetch PC)
//               imem_rdata   - memory read data, one cycle after the address
//               redirect     - flush the queue and restart at redirect_pc
//               redirect_pc  - new fetch PC (bits [1:0] forced to zero)
//               instr_valid  - head entry is valid
//               instr_ready  - consumer accepts the head entry this cycle
//               instr        - head instruction word
//               instr_pc     - PC of the head instruction
//               count        - current FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [31:0]              imem_raddr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [63:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [63:0]     r_fpc;
    logic            r_inflight;
    logic [63:0]     r_inflight_pc;
    logic [31:0]     r_fifo_instr [DEPTH];
    logic [63:0]     r_fifo_pc    [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_occ;

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CW1-1:0]  w_credit;

    assign imem_raddr  = r_fpc[31:0];
    assign instr_valid = (r_occ != '0);
    assign instr       = r_fifo_instr[r_rptr];
    assign instr_pc    = r_fifo_pc[r_rptr];
    assign count       = r_occ;

    assign w_pop  = instr_valid && instr_ready;
    // A redirect in the same cycle kills the returning word.
    assign w_push = r_inflight && !redirect;

    // Slots already spoken for: stored entries plus the outstanding read,
    // less the entry leaving this cycle. Lets issue resume on the pop cycle.
    assign w_credit = {1'b0, r_occ} + CW1'(r_inflight) - CW1'(w_pop);

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_en) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (!fetch_en) w_next_state = S_IDLE;
                w_issue = fetch_en && !redirect && (w_credit < CW1'(DEPTH));
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_occ         <= '0;
        end else if (redirect) begin
            r_fpc      <= {redirect_pc[63:2], 2'b00};
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_occ      <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fpc;
                r_fpc         <= r_fpc + 64'd4;
            end
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else if (w_push) begin
            r_fifo_instr[r_wptr] <= imem_rdata;
            r_fifo_pc[r_wptr]    <= r_inflight_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Testbench for instr_fetch_queue (DEPTH=4, RESET_PC=0). The
//               memory returns its own address as data. Expected PCs are
//               queued by the stimulus; a monitor compares every accepted
//               head entry against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [2:0]  count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .imem_raddr  (imem_raddr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory whose word equals its address.
    initial imem_rdata = '0;
    always @(posedge clk) imem_rdata <= imem_raddr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
    endtask

    // Scoreboard monitor: every accepted head entry must be the next expected.
    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc %0h expected no entry", instr_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", instr_pc, e);
                chk("pop_instr", 64'(instr), {32'h0, e[31:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        cyc(2);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'h0);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_instr_pc", instr_pc, 64'h0);
        chk("rst_raddr", 64'(imem_raddr), 64'h0);

        // Streaming from reset, then a 5-cycle fetch_en drop and resume.
        push_range(64'h0, 9);
        push_range(64'h24, 3);
        rst_n       = 1'b1;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        cyc(2);
        chk("latency_not_yet", 64'(instr_valid), 64'h0);
        cyc(1);
        chk("latency_valid", 64'(instr_valid), 64'h1);
        chk("first_pc", instr_pc, 64'h0);
        cyc(7);
        fetch_en = 1'b0;
        cyc(5);
        chk("drop_count", 64'(count), 64'h0);
        chk("drop_fpc_hold", 64'(imem_raddr), 64'h24);
        fetch_en = 1'b1;
        cyc(4);
        fetch_en = 1'b0;
        cyc(5);
        chk("resume_count", 64'(count), 64'h0);
        chk("resume_raddr", 64'(imem_raddr), 64'h30);

        // Fill with ready low, then drain in order.
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        instr_ready = 1'b0;
        fetch_en    = 1'b1;
        cyc(1);
        redirect = 1'b0;
        cyc(7);
        chk("full_count", 64'(count), 64'h4);
        chk("full_raddr", 64'(imem_raddr), 64'h10);
        chk("full_valid", 64'(instr_valid), 64'h1);
        chk("full_head_pc", instr_pc, 64'h0);
        push_range(64'h0, 8);
        instr_ready = 1'b1;
        cyc(4);
        fetch_en = 1'b0;
        cyc(8);
        chk("full_drain_count", 64'(count), 64'h0);
        chk("full_drain_raddr", 64'(imem_raddr), 64'h20);

        // Steady push+pop at occupancy 2.
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        fetch_en    = 1'b1;
        cyc(1);
        redirect = 1'b0;
        cyc(3);
        chk("steady_start_count", 64'(count), 64'h2);
        push_range(64'h200, 13);
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("steady_count", 64'(count), 64'h2);
            cyc(1);
        end
        fetch_en = 1'b0;
        cyc(8);
        chk("steady_drain_count", 64'(count), 64'h0);

        // Redirect with 3 queued and 1 in flight.
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        fetch_en    = 1'b1;
        cyc(1);
        redirect = 1'b0;
        cyc(7);
        chk("redir_full_count", 64'(count), 64'h4);
        push_range(64'h300, 1);
        instr_ready = 1'b1;
        cyc(1);
        chk("redir_pre_count", 64'(count), 64'h3);
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        cyc(1);
        redirect = 1'b0;
        chk("redir_count", 64'(count), 64'h0);
        chk("redir_valid", 64'(instr_valid), 64'h0);
        chk("redir_raddr", 64'(imem_raddr), 64'h100);
        push_range(64'h100, 3);
        instr_ready = 1'b1;
        cyc(1);
        chk("redir_no_stale", 64'(instr_valid), 64'h0);
        cyc(1);
        chk("redir_first_valid", 64'(instr_valid), 64'h1);
        chk("redir_first_pc", instr_pc, 64'h100);
        cyc(1);
        fetch_en = 1'b0;
        cyc(8);
        chk("redir_drain_count", 64'(count), 64'h0);

        // Asynchronous reset mid-cycle with a full queue.
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h400;
        fetch_en    = 1'b1;
        cyc(1);
        redirect = 1'b0;
        cyc(7);
        chk("arst_pre_count", 64'(count), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(instr_valid), 64'h0);
        chk("arst_count", 64'(count), 64'h0);
        chk("arst_raddr", 64'(imem_raddr), 64'h0);
        chk("arst_instr_pc", instr_pc, 64'h0);
        chk("arst_instr", 64'(instr), 64'h0);
        fetch_en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_count", 64'(count), 64'h0);
        chk("post_rst_valid", 64'(instr_valid), 64'h0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage that sits directly upstream of the instruction register in the multicycle RISC-V core. It drives the read address of the 32-bit instruction memory and absorbs that memory's one-cycle read latency. Each returned word is stored with its PC in a small FIFO, and the FIFO presents instructions to the instruction register through a valid/ready handshake. The control unit can flush the queue and restart fetch at a new PC on branches and jumps.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, 2..16
- RESET_PC, 64'h0, fetch PC loaded on reset; bits [1:0] must be 0
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- fetch_en  in  1  when high, new fetch requests may issue
- imem_raddr  out  32  instruction memory read address; always equals fpc[31:0]
- imem_rdata  in  32  instruction memory read data; valid the cycle after the address is presented
- redirect  in  1  flush the queue and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch PC; bits [1:0] are ignored and treated as 0
- instr_valid  out  1  the head entry is valid
- instr_ready  in  1  consumer (LoadIR) accepts the head entry this cycle
- instr  out  32  head instruction word
- instr_pc  out  64  PC of the head instruction
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State registers:
  - fpc (64): next fetch PC.
  - inflight (1) and inflight_pc (64): one outstanding request.
  - FIFO storage: DEPTH x {32-bit instruction, 64-bit PC}.
  - Read/write pointers: wrap modulo DEPTH.
  - occ: occupancy counter.
  - FSM state.
- FSM:
  - IDLE: no issue. Goes to RUN when fetch_en=1.
  - RUN: issue allowed. Goes to IDLE when fetch_en=0.
  - An in-flight request still completes in IDLE.
  - redirect does not change the FSM state.
- pop = instr_valid && instr_ready.
- issue = (state==RUN) && fetch_en && !redirect && (occ + inflight - pop < DEPTH).
- On issue:
  - inflight <= 1, inflight_pc <= fpc, fpc <= fpc + 4.
  - fpc wraps modulo 2^64.
- Without issue: inflight <= 0.
- Data capture:
  - If inflight=1 and there is no redirect, write {imem_rdata, inflight_pc} at the write pointer.
  - The credit rule guarantees the FIFO never overflows.
  - No write is dropped unless a redirect occurs.
- Output:
  - instr and instr_pc come from the head entry.
  - instr_valid = (occ != 0).
- Simultaneous push and pop: occ is unchanged and both pointers advance.
- Pop on empty is impossible, because instr_valid=0 when empty.
- On redirect (highest priority):
  - occ <= 0 and both pointers <= 0.
  - inflight <= 0; returning data for that request is discarded.
  - fpc <= {redirect_pc[63:2], 2'b00}.
  - A pop in the same cycle is treated as accepted but has no further effect.
- imem_raddr is combinational from fpc. The memory always reads; only issued reads are tracked.

## Timing
- Reset values:
  - fpc = RESET_PC, so imem_raddr = RESET_PC[31:0].
  - instr_valid = 0, instr = 0, instr_pc = 0, count = 0.
  - inflight = 0, state = IDLE.
- Latency:
  - An address issued before edge k has its word captured at edge k+1.
  - instr_valid is high in the cycle after edge k+1.
  - Fetch-to-valid is 2 cycles from the first RUN cycle.
- Throughput: 1 instruction/cycle with instr_ready held high and DEPTH >= 2.
- Full condition: occ + inflight = DEPTH stops issue. Issue resumes in the cycle pop occurs.
- Redirect at edge k:
  - The first address at the new PC is presented in cycle k.
  - The first new instruction is valid after edge k+2.
  - No stale instruction is visible after edge k.
- reset asserted mid-operation: all state clears asynchronously. No partial entry survives.
- Reset deassertion is assumed synchronized externally to clock.

## Test plan
- Reset release, fetch_en=1, instr_ready=1, memory word = address:
  - instr_pc = 0, 4, 8, ... on consecutive cycles with instr = 0, 4, 8.
  - First instr_valid 2 cycles after RUN entry.
- instr_ready=0 with DEPTH=4:
  - Exactly 4 entries captured, count=4, imem_raddr stops at 0x10.
  - Raise ready: PCs 0, 4, 8, 0xC delivered in order, then 0x10 follows.
- redirect with redirect_pc=0x103 while 3 entries are queued and 1 is in flight:
  - count=0 next cycle; the in-flight word is discarded.
  - Next valid instr_pc = 0x100.
- Simultaneous pop and push at count=2 for 10 cycles: count stays 2 and the PC sequence has no gaps.
- fetch_en dropped for 5 cycles mid-stream:
  - Only the in-flight word is captured.
  - fpc holds; fetch resumes with no duplicate or skipped PC.
- reset asserted asynchronously mid-cycle with a full queue: instr_valid=0, count=0 and imem_raddr=RESET_PC immediately, before the next edge.
